// File: rtl/map_cell_expander_pkg.sv
// Shared constants and types for map-cell to display-pixel expansion.
// Cell geometry is SX x SY pixels on a 128x128 map.
package map_pkg;

    localparam int SX      = 8;
    localparam int SY      = 6;
    localparam int MAP_W   = 7;
    localparam int PIX_W   = 12;
    localparam int MAP_DIM = 128;

    localparam int DX_W     = $clog2(SX);
    localparam int DY_W     = $clog2(SY);
    localparam int SX_SHIFT = $clog2(SX);

    localparam logic [DX_W-1:0] DX_MAX = DX_W'(SX - 1);
    localparam logic [DY_W-1:0] DY_MAX = DY_W'(SY - 1);

    typedef logic [2*MAP_W-1:0] cell_addr_t;
    typedef logic [PIX_W-1:0]   pix_coord_t;

    typedef enum logic {
        IDLE,
        EMIT
    } exp_state_t;

endpackage

// File: rtl/map_cell_expander_cell_base_calc.sv
// Combinational cell origin: map {row, col} to the top-left display pixel.
// Uses shifts and adds only, so it can be dropped into any cell-origin path.
module cell_base_calc
    import map_pkg::*;
(
    input  logic [2*MAP_W-1:0] cell_addr,
    output logic [PIX_W-1:0]   base_row,
    output logic [PIX_W-1:0]   base_col
);

    pix_coord_t row_ext;
    pix_coord_t col_ext;

    assign row_ext = pix_coord_t'(cell_addr[2*MAP_W-1 -: MAP_W]);
    assign col_ext = pix_coord_t'(cell_addr[MAP_W-1:0]);

    // row*6 = row*4 + row*2; largest result 762 fits PIX_W without carry-out.
    assign base_row = (row_ext << 2) + (row_ext << 1);
    assign base_col = col_ext << SX_SHIFT;

endmodule

// File: rtl/map_cell_expander.sv
// Streams every display pixel covered by one map cell over valid/ready.
// Define MAP_CELL_EXPANDER_BORDER_EN to emit only the cell perimeter.
module map_cell_expander
    import map_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cell_valid,
    output logic               cell_ready,
    input  logic [2*MAP_W-1:0] cell_addr,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [PIX_W-1:0]   pixel_row,
    output logic [PIX_W-1:0]   pixel_column,
    output logic               pix_last,
    output logic               busy
);

    exp_state_t      state;
    pix_coord_t      base_row;
    pix_coord_t      base_col;
    pix_coord_t      calc_row;
    pix_coord_t      calc_col;
    logic [DX_W-1:0] dx;
    logic [DY_W-1:0] dy;
    logic [DX_W-1:0] dx_next;
    logic [DY_W-1:0] dy_next;

    cell_base_calc u_base (
        .cell_addr (cell_addr),
        .base_row  (calc_row),
        .base_col  (calc_col)
    );

    // NOTE: defaults first so every path assigns both outputs; no latch inferred.
    always_comb begin
        dx_next = dx + 1'b1;
        dy_next = dy;
        if (dx == DX_MAX) begin
            dx_next = '0;
            dy_next = dy + 1'b1;
        end
`ifdef MAP_CELL_EXPANDER_BORDER_EN
        else if (dx == '0 && dy != '0 && dy != DY_MAX) begin
            dx_next = DX_MAX;
        end
`endif
    end

    // NOTE: non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cell_ready   <= 1'b1;
            pix_valid    <= 1'b0;
            pix_last     <= 1'b0;
            busy         <= 1'b0;
            pixel_row    <= '0;
            pixel_column <= '0;
            base_row     <= '0;
            base_col     <= '0;
            dx           <= '0;
            dy           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cell_valid && cell_ready) begin
                        base_row     <= calc_row;
                        base_col     <= calc_col;
                        dx           <= '0;
                        dy           <= '0;
                        pixel_row    <= calc_row;
                        pixel_column <= calc_col;
                        pix_last     <= 1'b0;
                        pix_valid    <= 1'b1;
                        cell_ready   <= 1'b0;
                        busy         <= 1'b1;
                        state        <= EMIT;
                    end
                end
                EMIT: begin
                    if (pix_ready) begin
                        if (pix_last) begin
                            pix_valid  <= 1'b0;
                            pix_last   <= 1'b0;
                            cell_ready <= 1'b1;
                            busy       <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            dx           <= dx_next;
                            dy           <= dy_next;
                            pixel_row    <= base_row + pix_coord_t'(dy_next);
                            pixel_column <= base_col + pix_coord_t'(dx_next);
                            pix_last     <= (dy_next == DY_MAX) && (dx_next == DX_MAX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_map_cell_expander.sv
// Directed bench for map_cell_expander: table of cells plus hand-written
// back-to-back and mid-expansion reset sequences.
module tb_map_cell_expander;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cell_valid;
    logic        cell_ready;
    logic [13:0] cell_addr;
    logic        pix_valid;
    logic        pix_ready;
    logic [11:0] pixel_row;
    logic [11:0] pixel_column;
    logic        pix_last;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef MAP_CELL_EXPANDER_BORDER_EN
    localparam bit BORDER    = 1'b1;
    localparam int CELL_PIX  = 24;
`else
    localparam bit BORDER    = 1'b0;
    localparam int CELL_PIX  = 48;
`endif

    map_cell_expander dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cell_valid   (cell_valid),
        .cell_ready   (cell_ready),
        .cell_addr    (cell_addr),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pixel_row    (pixel_row),
        .pixel_column (pixel_column),
        .pix_last     (pix_last),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Offers one cell at the current negedge and consumes all its pixels.
    // With hold set, cell_valid stays high carrying hold_addr during EMIT.
    task automatic expand(input logic [6:0] r, input logic [6:0] c, input bit bp,
                          input bit hold, input logic [13:0] hold_addr,
                          output int beats, output logic [11:0] fr, output logic [11:0] fc,
                          output logic [11:0] lr, output logic [11:0] lc);
        int er[48];
        int ec[48];
        int el[48];
        int n   = 0;
        int idx = 0;
        int cyc = 0;
        bit stalled = 1'b0;
        logic [11:0] hr, hc;
        logic hl;
        for (int y = 0; y < 6; y++) begin
            for (int x = 0; x < 8; x++) begin
                if (!(BORDER && y != 0 && y != 5 && x != 0 && x != 7)) begin
                    er[n] = int'(r) * 6 + y;
                    ec[n] = int'(c) * 8 + x;
                    el[n] = (y == 5 && x == 7) ? 1 : 0;
                    n++;
                end
            end
        end
        fr = '0; fc = '0; lr = '0; lc = '0; hr = '0; hc = '0; hl = 1'b0;
        while (!cell_ready && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("ready_before_offer", 32'(cell_ready), 32'd1);
        cell_valid = 1'b1;
        cell_addr  = {r, c};
        @(negedge clk);
        if (hold) cell_addr = hold_addr;
        else      cell_valid = 1'b0;
        check("first_pixel_latency", 32'(pix_valid), 32'd1);
        cyc = 0;
        while (idx < n && cyc < 400) begin
            pix_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            if (stalled) begin
                check("stall_row_stable", 32'(pixel_row), 32'(hr));
                check("stall_col_stable", 32'(pixel_column), 32'(hc));
                check("stall_last_stable", 32'(pix_last), 32'(hl));
            end
            if (hold) check("busy_rejects_cell", 32'({cell_ready, busy}), 32'b01);
            stalled = 1'b0;
            if (pix_valid) begin
                if (pix_ready) begin
                    if (idx == 0) begin fr = pixel_row; fc = pixel_column; end
                    lr = pixel_row;
                    lc = pixel_column;
                    check("beat_row", 32'(pixel_row), 32'(er[idx]));
                    check("beat_col", 32'(pixel_column), 32'(ec[idx]));
                    check("beat_last", 32'(pix_last), 32'(el[idx]));
                    idx++;
                end else begin
                    stalled = 1'b1;
                    hr = pixel_row;
                    hc = pixel_column;
                    hl = pix_last;
                end
            end
            @(negedge clk);
            cyc++;
        end
        beats = idx;
        check("beat_count", 32'(idx), 32'(n));
        check("turnaround_ready", 32'(cell_ready), 32'd1);
        check("turnaround_no_valid", 32'(pix_valid), 32'd0);
        check("turnaround_not_busy", 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic [6:0]  r;
        logic [6:0]  c;
        bit          bp;
        logic [11:0] fr, fc, lr, lc;
    } vec_t;

    initial begin
        vec_t vecs[4];
        int beats;
        int cnt;
        int cyc;
        logic [11:0] fr, fc, lr, lc;

        vecs[0] = '{r: 7'd0,   c: 7'd0,   bp: 1'b0, fr: 12'd0,   fc: 12'd0,    lr: 12'd5,   lc: 12'd7};
        vecs[1] = '{r: 7'd127, c: 7'd127, bp: 1'b0, fr: 12'd762, fc: 12'd1016, lr: 12'd767, lc: 12'd1023};
        vecs[2] = '{r: 7'd3,   c: 7'd2,   bp: 1'b1, fr: 12'd18,  fc: 12'd16,   lr: 12'd23,  lc: 12'd23};
        vecs[3] = '{r: 7'd64,  c: 7'd1,   bp: 1'b1, fr: 12'd384, fc: 12'd8,    lr: 12'd389, lc: 12'd15};

        rst_n      = 1'b0;
        cell_valid = 1'b0;
        cell_addr  = '0;
        pix_ready  = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_cell_ready", 32'(cell_ready), 32'd1);
        check("reset_pix_valid", 32'(pix_valid), 32'd0);
        check("reset_pix_last", 32'(pix_last), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_pixel_row", 32'(pixel_row), 32'd0);
        check("reset_pixel_col", 32'(pixel_column), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            expand(vecs[i].r, vecs[i].c, vecs[i].bp, 1'b0, '0, beats, fr, fc, lr, lc);
            check("vec_beats", 32'(beats), 32'(CELL_PIX));
            check("vec_first_row", 32'(fr), 32'(vecs[i].fr));
            check("vec_first_col", 32'(fc), 32'(vecs[i].fc));
            check("vec_last_row", 32'(lr), 32'(vecs[i].lr));
            check("vec_last_col", 32'(lc), 32'(vecs[i].lc));
        end

        // Back-to-back: {4,5} is offered throughout the {2,3} expansion.
        expand(7'd2, 7'd3, 1'b0, 1'b1, {7'd4, 7'd5}, beats, fr, fc, lr, lc);
        expand(7'd4, 7'd5, 1'b0, 1'b0, '0, beats, fr, fc, lr, lc);
        check("b2b_first_row", 32'(fr), 32'd24);
        check("b2b_first_col", 32'(fc), 32'd40);

        // Reset after 10 accepted pixels abandons the cell.
        cell_valid = 1'b1;
        cell_addr  = {7'd10, 7'd20};
        @(negedge clk);
        cell_valid = 1'b0;
        pix_ready  = 1'b1;
        cnt = 0;
        cyc = 0;
        while (cnt < 10 && cyc < 50) begin
            if (pix_valid) cnt++;
            @(negedge clk);
            cyc++;
        end
        check("pre_reset_beats", 32'(cnt), 32'd10);
        rst_n     = 1'b0;
        pix_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midreset_pix_valid", 32'(pix_valid), 32'd0);
        check("midreset_cell_ready", 32'(cell_ready), 32'd1);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_pixel_row", 32'(pixel_row), 32'd0);
        check("midreset_pixel_col", 32'(pixel_column), 32'd0);
        pix_ready = 1'b1;
        @(negedge clk);
        check("postreset_no_pixels", 32'(pix_valid), 32'd0);
        expand(7'd10, 7'd20, 1'b0, 1'b0, '0, beats, fr, fc, lr, lc);
        check("restart_first_row", 32'(fr), 32'd60);
        check("restart_first_col", 32'(fc), 32'd160);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/map_cell_expander.md
# map_cell_expander

- Expands one world-map cell address into every display pixel that cell covers.
- Upscale path: cell {row[6:0], col[6:0]} maps to an SY×SX pixel block (6 rows × 8 columns), streamed row-major over a valid/ready interface.
- Sits between the map-update / overlay logic and the frame-buffer or icon writer.
- Together with the downscale path (pixel → cell address), every map edit lands on exactly the pixels that read back that cell.

## Interface
- SX, 8, pixel columns per cell (power of two)
- SY, 6, pixel rows per cell
- MAP_W, 7, bits per map coordinate (128×128 map)
- PIX_W, 12, pixel coordinate width
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset: one clock; reset is synchronous and active-low
- cell_valid  in  1  cell_addr is offered
- cell_ready  out  1  expander can accept a cell
- cell_addr  in  2*MAP_W  {map_row, map_col}; row in upper MAP_W bits
- pix_valid  out  1  pixel_row/pixel_column are valid
- pix_ready  in  1  downstream accepts the pixel
- pixel_row  out  PIX_W  display row
- pixel_column  out  PIX_W  display column
- pix_last  out  1  marks the final pixel of the current cell
- busy  out  1  a cell is being expanded

## Operation
- States: IDLE, EMIT.
- **IDLE**
  - cell_ready=1, pix_valid=0.
  - On cell_valid&&cell_ready, latch:
    - base_row = map_row*SY, computed as (row<<2)+(row<<1), zero-extended to PIX_W.
    - base_col = map_col*SX, computed as col<<3.
  - Clear the offsets dy=0, dx=0, then go to EMIT.
- **EMIT**
  - cell_ready=0, pix_valid=1.
  - pixel_row = base_row+dy; pixel_column = base_col+dx.
  - cell_valid is ignored while in EMIT.
- **Pixel step:** a pixel advances only on pix_valid&&pix_ready.
  - dx increments.
  - At dx=SX-1: dx wraps to 0 and dy increments.
- **pix_last** = (dy==SY-1)&&(dx==SX-1).
  - Handshake with pix_last → IDLE.
- **Output stability:** pixel_row, pixel_column and pix_last hold stable while pix_valid&&!pix_ready.
- **busy** = (state==EMIT).
- **Arithmetic:** maximum coordinates are base_row 762+5=767 and base_col 1016+7=1023; all fit in PIX_W with no overflow or clipping.

## Timing
- **Reset:** state=IDLE, cell_ready=1, pix_valid=0, pix_last=0, busy=0, pixel_row=0, pixel_column=0, internal dx/dy/base cleared.
- **Reset mid-EMIT:** the cell is abandoned. The next cycle shows the reset values, and no further pixels are emitted.
- **Latency:** cell accepted at edge N → first pixel valid in cycle N+1.
- **Throughput:** one pixel per cycle under continuous pix_ready. A full cell takes SX*SY=48 cycles in EMIT.
- **Turnaround:** pix_last accepted at edge M → IDLE with cell_ready=1 in cycle M+1. The next cell's first pixel appears at M+2, giving one bubble between cells.
- **Outputs:** registered; no combinational path from cell_valid or pix_ready to any output.

## Configuration
- Macro: MAP_CELL_EXPANDER_BORDER_EN.
- **Defined:** only the cell's perimeter is emitted.
  - For dy=0 or dy=SY-1, all dx values are emitted.
  - For interior rows, dx steps 0 → SX-1 directly, then to the next row.
  - pix_last still marks (SY-1, SX-1).
  - This gives 2*SX+2*(SY-2)=24 pixels per cell.
- **Undefined:** the full block is emitted, 48 pixels per cell.
- Latency and handshake rules are identical in both builds.

## Structure
- **Package map_pkg:**
  - constants SX, SY, MAP_W, PIX_W, MAP_DIM=128
  - typedef cell_addr_t (2*MAP_W bits)
  - typedef pix_coord_t (PIX_W bits)
  - enum exp_state_t {IDLE, EMIT}
- **Sub-module cell_base_calc:** purely combinational.
  - Maps cell_addr_t to base_row and base_col using shifts/adds, with no divider or multiplier.
  - Reusable by other blocks that need cell origins.

## Test plan
- Full cell 0: cell_addr=0, pix_ready=1.
  - Required: 48 beats, (0,0),(0,1)…(0,7),(1,0)…(5,7).
  - pix_last only on (5,7); cell_ready back high one cycle later.
- Corner cell: cell_addr={7'd127,7'd127}.
  - Required: first pixel (762,1016), last (767,1023), no wrap.
- Backpressure: cell {7'd3,7'd2}, pix_ready toggles 1,0,0,1 repeating.
  - Required: coordinates stable while stalled.
  - Required: sequence starts (18,16) and ends (23,23); exactly 48 accepted beats.
- Busy rejection and back-to-back: cell_valid held high with new addresses during EMIT.
  - Required: cell_ready=0, none latched; the next cell is taken only after pix_last, with one bubble.
- Reset mid-expansion: rst_n low after 10 accepted pixels.
  - Required: pix_valid=0 and cell_ready=1 the next cycle; a new cell restarts at dy=dx=0.
- BORDER_EN build, cell 0.
  - Required: 24 beats; row 1 emits only (1,0),(1,7); ends with pix_last on (5,7).
